// File: rtl/nat_pkg.sv
// Shared types and constants for the NAT connection responder: tuple layout,
// FSM encoding and reserved connection-ID codes.
package nat_pkg;

   localparam int NAT_IP_W    = 32;
   localparam int NAT_PORT_W  = 16;
   localparam int NAT_PROTO_W = 8;
   localparam int NAT_TUPLE_W = 2 * NAT_IP_W + 2 * NAT_PORT_W + NAT_PROTO_W;

   // Packed 104-bit tuple, src_ip in the least significant bits
   typedef struct packed {
      logic [NAT_PROTO_W-1:0] proto;
      logic [NAT_PORT_W-1:0]  dstPort;
      logic [NAT_PORT_W-1:0]  srcPort;
      logic [NAT_IP_W-1:0]    dstIp;
      logic [NAT_IP_W-1:0]    srcIp;
   } nat_tuple_t;

   localparam logic [2:0] ST_RECV0  = 3'd0;
   localparam logic [2:0] ST_RECV1  = 3'd1;
   localparam logic [2:0] ST_RECV2  = 3'd2;
   localparam logic [2:0] ST_RECV3  = 3'd3;
   localparam logic [2:0] ST_SEARCH = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   localparam logic [31:0] NAT_ID_FULL     = 32'hFFFF_FFFF;
   localparam logic [31:0] NAT_ID_BADPROTO = 32'hFFFF_FFFE;

   function automatic logic isRecvState(input logic [2:0] st);
      return (st == ST_RECV0) || (st == ST_RECV1) ||
             (st == ST_RECV2) || (st == ST_RECV3);
   endfunction

endpackage

// File: rtl/nat_tuple_table.sv
// Connection table storage with one combinational compare port and one write
// port; entries are never cleared, validity is tracked by the caller's count.
module nat_tuple_table
   import nat_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
   input  nat_tuple_t               cmp_tuple_i,
   output logic                     match_o,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
   input  nat_tuple_t               wr_tuple_i
);

   nat_tuple_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_tuple_i;
      end
   end

   assign match_o = (mem_q[rd_idx_i] == cmp_tuple_i);

endmodule

// File: rtl/nat_conn_responder.sv
// Receives 4-word 5-tuples, linearly searches the connection table and answers
// with the matching or newly allocated ID. Optional NAT_PROTO_CHECK_EN rejects
// tuples whose protocol word has nonzero upper bits.
module nat_conn_responder
   import nat_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tuple_valid_i,
   input  logic [31:0] tuple_data_i,
   output logic        tuple_ready_o,
   output logic        conn_valid_o,
   output logic [31:0] conn_data_o,
   input  logic        conn_ready_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] idx_q, idx_d;
   logic [31:0]   connData_q, connData_d;
   nat_tuple_t    tuple_q, tuple_d;

   logic          wordAccept;
   logic          tblMatch;
   logic          tblWrEn;
   logic          lastIdx;
   logic          tableFull;

   assign tuple_ready_o = isRecvState(state_q);
   assign conn_valid_o  = (state_q == ST_RESP);
   assign conn_data_o   = connData_q;

   assign wordAccept = tuple_valid_i && tuple_ready_o;
   assign lastIdx    = (idx_q == (count_q - CW'(1)));
   assign tableFull  = (count_q == CW'(DEPTH));

   nat_tuple_table #(
      .DEPTH (DEPTH)
   ) u_table (
      .clk         (clk),
      .rd_idx_i    (idx_q[AW-1:0]),
      .cmp_tuple_i (tuple_q),
      .match_o     (tblMatch),
      .wr_en_i     (tblWrEn),
      .wr_idx_i    (count_q[AW-1:0]),
      .wr_tuple_i  (tuple_q)
   );

   // Next-state logic: assemble the tuple, then walk entries 0..count-1,
   // inserting at index count when the last valid entry misses.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      idx_d      = idx_q;
      connData_d = connData_q;
      tuple_d    = tuple_q;
      tblWrEn    = 1'b0;

      case (state_q)
         ST_RECV0: begin
            if (wordAccept) begin
               tuple_d.srcIp = tuple_data_i;
               state_d       = ST_RECV1;
            end
         end
         ST_RECV1: begin
            if (wordAccept) begin
               tuple_d.dstIp = tuple_data_i;
               state_d       = ST_RECV2;
            end
         end
         ST_RECV2: begin
            if (wordAccept) begin
               tuple_d.dstPort = tuple_data_i[31:16];
               tuple_d.srcPort = tuple_data_i[15:0];
               state_d         = ST_RECV3;
            end
         end
         ST_RECV3: begin
            if (wordAccept) begin
               tuple_d.proto = tuple_data_i[7:0];
               idx_d         = '0;
               state_d       = ST_SEARCH;
`ifdef NAT_PROTO_CHECK_EN
               if (|tuple_data_i[31:8]) begin
                  connData_d = NAT_ID_BADPROTO;
                  state_d    = ST_RESP;
               end
`endif
            end
         end
         ST_SEARCH: begin
            if (count_q == '0) begin
               tblWrEn    = 1'b1;
               count_d    = CW'(1);
               connData_d = '0;
               state_d    = ST_RESP;
            end else if (tblMatch) begin
               connData_d = 32'(idx_q);
               state_d    = ST_RESP;
            end else if (lastIdx) begin
               state_d = ST_RESP;
               if (tableFull) begin
                  connData_d = NAT_ID_FULL;
               end else begin
                  tblWrEn    = 1'b1;
                  count_d    = count_q + CW'(1);
                  connData_d = 32'(count_q);
               end
            end else begin
               idx_d = idx_q + CW'(1);
            end
         end
         ST_RESP: begin
            if (conn_ready_i) begin
               state_d = ST_RECV0;
            end
         end
         default: begin
            state_d = ST_RECV0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RECV0;
         count_q    <= '0;
         idx_q      <= '0;
         connData_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         connData_q <= connData_d;
      end
   end

   // The tuple holding register needs no reset: it is always fully rewritten
   // before SEARCH reads it.
   always_ff @(posedge clk) begin
      tuple_q <= tuple_d;
   end

endmodule

// File: doc/nat_conn_responder.md
NAT_CONN_RESPONDER -- requirements
Module: nat_conn_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of connection-table entries (power of two, 2..1024).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port tuple_valid_i  input  1  tuple word valid.
REQ-005 SHALL have port tuple_data_i  input  32  tuple word.
REQ-006 SHALL have port tuple_ready_o  output  1  ready to accept a tuple word.
REQ-007 SHALL have port conn_valid_o  output  1  connection ID valid.
REQ-008 SHALL have port conn_data_o  output  32  connection ID or error code.
REQ-009 SHALL have port conn_ready_i  input  1  consumer accepts connection ID.

Function
REQ-010 SHALL transfer a word on any rising edge where valid and ready are both high, on either stream.
REQ-011 SHALL receive each tuple as 4 words in order: W0 src_ip, W1 dst_ip, W2 {dst_port[31:16], src_port[15:0]}, W3 protocol in [7:0].
REQ-012 SHALL implement states RECV0, RECV1, RECV2, RECV3, SEARCH, RESP; each RECVn advances to the next on acceptance of word n; RECV3 goes to SEARCH with idx=0.
REQ-013 SHALL drive tuple_ready_o high in RECV0..RECV3 only, and conn_valid_o high in RESP only.
REQ-014 SHALL compare, in SEARCH, the full 104-bit tuple against table entry idx (one entry per cycle), for idx < count.
REQ-015 SHALL, on a match at idx k, enter RESP with conn_data_o = k (zero-extended) at the next edge; no table write.
REQ-016 SHALL, when count==0 or the entry compared is idx==count-1 without a match, store the tuple at index count, increment count, and enter RESP with conn_data_o = old count.
REQ-017 SHALL, on a miss while count==DEPTH, enter RESP with conn_data_o = 32'hFFFF_FFFF and leave table and count unchanged.
REQ-018 SHALL give latency: a hit at entry k raises conn_valid_o k+1 cycles after the edge accepting W3; a miss with count=c raises it max(c,1) cycles after that edge.
REQ-019 SHALL hold conn_valid_o and conn_data_o stable in RESP until the edge where conn_ready_i is high, then return to RECV0.
REQ-020 SHALL ignore tuple_valid_i outside RECV states and conn_ready_i outside RESP.
REQ-021 SHALL allow conn_ready_i to be high before conn_valid_o rises; the handshake completes on the first RESP cycle.

Reset
REQ-022 SHALL, while rst is high at an edge, set state=RECV0, count=0, idx=0, conn_data_o=0, conn_valid_o=0; tuple_ready_o=1 in the cycle after.
REQ-023 SHALL abandon any partial tuple, search, or pending response on reset; table storage needs no clearing since count gates validity.

Configuration
REQ-024 SHALL, with NAT_PROTO_CHECK_EN defined, treat W3[31:8]!=0 as malformed: skip search, enter RESP next cycle with conn_data_o = 32'hFFFF_FFFE, no insert.
REQ-025 SHALL, without NAT_PROTO_CHECK_EN, ignore W3[31:8] entirely (store and compare protocol[7:0] only).

Structure
REQ-026 SHALL take from shared package nat_pkg: tuple field widths, 104-bit tuple packing layout, state encoding, constants NAT_ID_FULL=32'hFFFF_FFFF and NAT_ID_BADPROTO=32'hFFFF_FFFE.
REQ-027 SHALL place storage plus equality compare in sub-module nat_tuple_table (one read/compare port, one write port, DEPTH parameter).

Verification
REQ-028 SHALL cover: after reset, tuple A (10.0.0.1, 8.8.8.8, 1234, 53, 17) -> ID 0, conn_valid_o 1 cycle after W3 accept.
REQ-029 SHALL cover: A, B, A -> IDs 0, 1, 0; second A response 1 cycle after W3 (hit at k=0).
REQ-030 SHALL cover: DEPTH=4, five distinct tuples -> 0,1,2,3,FFFF_FFFF; then repeat of tuple 3 -> 3.
REQ-031 SHALL cover: conn_ready_i low for 5 cycles in RESP -> conn_data_o stable, tuple_ready_o low throughout.
REQ-032 SHALL cover: rst asserted after W1 of tuple B with count=1 -> next tuple B gets ID 0.
REQ-033 SHALL cover: with NAT_PROTO_CHECK_EN, W3=32'h0000_0111 -> FFFF_FFFE, count unchanged; without it -> new ID, later W3=32'h0000_0011 same tuple hits.
